dict_table_loader: RTL and testbench

//  Boot-time sequencer for the three compression dictionaries. On start it fetches the

---
 rtl/dict_table_loader.sv | 145 ++++++++++++++
 tb/tb_dict_table_loader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dict_table_loader.sv
// rtl/dict_table_loader.sv - boot-time loader that fetches the dictionary table and programs dict1/2/3
module dict_table_loader #(
  parameter int unsigned FIELD1_VAL_WIDTH = 7,
  parameter int unsigned FIELD2_VAL_WIDTH = 10,
  parameter int unsigned FIELD3_VAL_WIDTH = 15,
  parameter int unsigned FIELD1_ENTRIES   = 8,
  parameter int unsigned FIELD2_ENTRIES   = 32,
  parameter int unsigned FIELD3_ENTRIES   = 256,
  parameter logic [31:0] TABLE_BASE       = 32'h0001_0000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  input  logic                        ctrl_mem_req_valid,
  input  logic [31:0]                 ctrl_mem_req_addr,
  output logic                        ctrl_mem_req_ready,
  output logic [31:0]                 ctrl_mem_req_rdata,
  output logic                        mem_req_valid,
  output logic [31:0]                 mem_req_addr,
  input  logic                        mem_req_ready,
  input  logic [31:0]                 mem_req_rdata,
  output logic                        dict1_write_enable,
  output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
  output logic                        dict2_write_enable,
  output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
  output logic                        dict3_write_enable,
  output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val
);

  // Field boundaries expressed as word indices.
  localparam logic [31:0] FIELD1_END = 32'(FIELD1_ENTRIES);
  localparam logic [31:0] FIELD2_END = 32'(FIELD1_ENTRIES + FIELD2_ENTRIES);
  localparam logic [31:0] LAST_IDX   = 32'(FIELD1_ENTRIES + FIELD2_ENTRIES + FIELD3_ENTRIES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE
  } state_t;

  // Per-word sub-phase inside LOAD: address setup, request outstanding, post-capture gap.
  typedef enum logic [1:0] {
    PH_SETUP,
    PH_REQ,
    PH_GAP
  } phase_t;

  state_t      state;
  phase_t      phase;
  logic [31:0] word_idx;
  logic        load_valid;
  logic [31:0] load_addr;

  // Loader FSM: sequences one table word at a time and emits registered dictionary write pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      phase              <= PH_SETUP;
      word_idx           <= 32'd0;
      load_valid         <= 1'b0;
      load_addr          <= 32'd0;
      busy               <= 1'b0;
      done               <= 1'b0;
      dict1_write_enable <= 1'b0;
      dict1_write_val    <= '0;
      dict2_write_enable <= 1'b0;
      dict2_write_val    <= '0;
      dict3_write_enable <= 1'b0;
      dict3_write_val    <= '0;
    end else begin
      // Write pulses last exactly one cycle; values are cleared between pulses.
      dict1_write_enable <= 1'b0;
      dict1_write_val    <= '0;
      dict2_write_enable <= 1'b0;
      dict2_write_val    <= '0;
      dict3_write_enable <= 1'b0;
      dict3_write_val    <= '0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            phase    <= PH_SETUP;
            word_idx <= 32'd0;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          case (phase)
            PH_SETUP: begin
              load_addr  <= TABLE_BASE + (word_idx << 2);
              load_valid <= 1'b1;
              phase      <= PH_REQ;
            end
            PH_REQ: begin
              if (mem_req_ready) begin
                load_valid <= 1'b0;
                phase      <= PH_GAP;
                if (word_idx < FIELD1_END) begin
                  dict1_write_enable <= 1'b1;
                  dict1_write_val    <= mem_req_rdata[FIELD1_VAL_WIDTH-1:0];
                end else if (word_idx < FIELD2_END) begin
                  dict2_write_enable <= 1'b1;
                  dict2_write_val    <= mem_req_rdata[FIELD2_VAL_WIDTH-1:0];
                end else begin
                  dict3_write_enable <= 1'b1;
                  dict3_write_val    <= mem_req_rdata[FIELD3_VAL_WIDTH-1:0];
                end
              end
            end
            default: begin
              // Gap cycle: a ready seen here belongs to no request and is ignored.
              if (word_idx == LAST_IDX) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                word_idx <= word_idx + 32'd1;
                phase    <= PH_SETUP;
              end
            end
          endcase
        end
        default: begin
          // Reload only when the controller has nothing in flight.
          if (start && !ctrl_mem_req_valid) begin
            state    <= ST_LOAD;
            phase    <= PH_SETUP;
            word_idx <= 32'd0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
      endcase
    end
  end

  // Port ownership: the controller is wired straight through to memory once loading is done.
  assign mem_req_valid      = (state == ST_DONE) ? ctrl_mem_req_valid : load_valid;
  assign mem_req_addr       = (state == ST_DONE) ? ctrl_mem_req_addr  : load_addr;
  assign ctrl_mem_req_ready = (state == ST_DONE) & mem_req_ready;
  assign ctrl_mem_req_rdata = mem_req_rdata;

endmodule

// File: tb/tb_dict_table_loader.sv
// tb/tb_dict_table_loader.sv - directed self-checking bench for dict_table_loader
module tb_dict_table_loader;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          TOTAL = 296;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        busy, done;
  logic        ctrl_mem_req_valid;
  logic [31:0] ctrl_mem_req_addr;
  logic        ctrl_mem_req_ready;
  logic [31:0] ctrl_mem_req_rdata;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic [31:0] mem_req_rdata;
  logic        dict1_write_enable, dict2_write_enable, dict3_write_enable;
  logic [6:0]  dict1_write_val;
  logic [9:0]  dict2_write_val;
  logic [14:0] dict3_write_val;

  dict_table_loader dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .busy               (busy),
    .done               (done),
    .ctrl_mem_req_valid (ctrl_mem_req_valid),
    .ctrl_mem_req_addr  (ctrl_mem_req_addr),
    .ctrl_mem_req_ready (ctrl_mem_req_ready),
    .ctrl_mem_req_rdata (ctrl_mem_req_rdata),
    .mem_req_valid      (mem_req_valid),
    .mem_req_addr       (mem_req_addr),
    .mem_req_ready      (mem_req_ready),
    .mem_req_rdata      (mem_req_rdata),
    .dict1_write_enable (dict1_write_enable),
    .dict1_write_val    (dict1_write_val),
    .dict2_write_enable (dict2_write_enable),
    .dict2_write_val    (dict2_write_val),
    .dict3_write_enable (dict3_write_enable),
    .dict3_write_val    (dict3_write_val)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // memory model controls and state
  int mem_lat = 0;
  bit spur_gap = 1'b0;
  int wait_cnt = 0;
  bit genuine_prev = 1'b0;

  // monitor tallies
  int wr_count = 0;
  int cnt1 = 0, cnt2 = 0, cnt3 = 0;
  int bad = 0, multi = 0, nocause = 0, gap_viol = 0, leak = 0;
  int last_we_cyc = 0, done_rise_cyc = 0;
  bit done_q = 1'b0;
  bit prev_cap = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a >= BASE && a < BASE + 32'(4 * TOTAL))
      return 32'hA500_0000 | ((a - BASE) >> 2);
    return 32'hDEAD_0000 | {16'h0000, a[15:0]};
  endfunction

  always @(posedge clk) cyc++;

  // memory: ready pulses after mem_lat waiting cycles, never two cycles in a row unless spurious
  always @(posedge clk) begin
    bit gen_now;
    #1;
    gen_now = 1'b0;
    if (mem_req_valid && !mem_req_ready) begin
      if (wait_cnt >= mem_lat) begin
        mem_req_ready = 1'b1;
        mem_req_rdata = mem_word(mem_req_addr);
        wait_cnt      = 0;
        gen_now       = 1'b1;
      end else begin
        mem_req_ready = 1'b0;
        wait_cnt++;
      end
    end else if (spur_gap && genuine_prev) begin
      mem_req_ready = 1'b1;
      mem_req_rdata = 32'hFFFF_FFFF;
    end else begin
      mem_req_ready = 1'b0;
      wait_cnt      = 0;
    end
    genuine_prev = gen_now;
  end

  // monitor: checks every write pulse against the table word it should carry
  always @(negedge clk) begin
    int nwe, exp_dict, got_dict;
    logic [31:0] got_val, exp_val;
    if (!reset) begin
      nwe = int'(dict1_write_enable) + int'(dict2_write_enable) + int'(dict3_write_enable);
      if (nwe > 1) multi++;
      if (nwe > 0 && !prev_cap) nocause++;
      if (nwe == 1) begin
        exp_dict = (wr_count < 8) ? 1 : (wr_count < 40) ? 2 : 3;
        if (dict1_write_enable) begin got_dict = 1; got_val = {25'd0, dict1_write_val}; end
        else if (dict2_write_enable) begin got_dict = 2; got_val = {22'd0, dict2_write_val}; end
        else begin got_dict = 3; got_val = {17'd0, dict3_write_val}; end
        exp_val = 32'(wr_count) & ((exp_dict == 1) ? 32'h7F : (exp_dict == 2) ? 32'h3FF : 32'h7FFF);
        if (got_dict != exp_dict || got_val != exp_val) bad++;
        if (got_dict == 1) cnt1++; else if (got_dict == 2) cnt2++; else cnt3++;
        wr_count++;
        last_we_cyc = cyc;
      end
      if (done && !done_q) done_rise_cyc = cyc;
      if (!done && (ctrl_mem_req_ready || (mem_req_valid && mem_req_addr == 32'h40))) leak++;
      if (prev_cap && busy && mem_req_valid) gap_viol++;
      prev_cap = busy && mem_req_valid && mem_req_ready;
    end else begin
      prev_cap = 1'b0;
    end
    done_q = done;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_tallies();
    wr_count = 0; cnt1 = 0; cnt2 = 0; cnt3 = 0;
    bad = 0; multi = 0; nocause = 0; gap_viol = 0; leak = 0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      step();
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic check_full_load(input string tag);
    chk({tag, "_writes"}, 32'(wr_count), 32'd296);
    chk({tag, "_values"}, 32'(bad), 32'd0);
    chk({tag, "_onehot"}, 32'(multi), 32'd0);
    chk({tag, "_nocause"}, 32'(nocause), 32'd0);
    chk({tag, "_gap"}, 32'(gap_viol), 32'd0);
  endtask

  initial begin
    bit ok;
    int bad_addr, saved;
    reset = 1'b1; start = 1'b0;
    ctrl_mem_req_valid = 1'b0; ctrl_mem_req_addr = 32'h0;
    mem_req_ready = 1'b0; mem_req_rdata = 32'h0;
    repeat (3) step();
    chk("rst_flags", {28'd0, busy, done, mem_req_valid, ctrl_mem_req_ready}, 32'd0);
    chk("rst_we", {29'd0, dict1_write_enable, dict2_write_enable, dict3_write_enable}, 32'd0);
    chk("rst_vals", {dict1_write_val, dict2_write_val, dict3_write_val}, 32'd0);
    reset = 1'b0;
    step();

    // T1 + T3: zero-latency load while the controller requests 0x40
    ctrl_mem_req_valid = 1'b1; ctrl_mem_req_addr = 32'h0000_0040;
    clear_tallies();
    pulse_start();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(2000, ok);
    chk("t1_timeout", {31'd0, ok}, 32'd1);
    check_full_load("t1");
    chk("t1_cnt1", 32'(cnt1), 32'd8);
    chk("t1_cnt2", 32'(cnt2), 32'd32);
    chk("t1_cnt3", 32'(cnt3), 32'd256);
    chk("t1_done_lat", 32'(done_rise_cyc - last_we_cyc), 32'd1);
    chk("t1_busy_low", {31'd0, busy}, 32'd0);
    chk("t3_leak", 32'(leak), 32'd0);
    chk("t3_addr", mem_req_addr, 32'h0000_0040);
    chk("t3_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("t3_ready", {31'd0, ctrl_mem_req_ready}, 32'd1);
    chk("t3_rdata", ctrl_mem_req_rdata, 32'hDEAD_0040);

    // T5: start in DONE with controller active is ignored
    pulse_start();
    chk("t5_done_hold", {30'd0, busy, done}, 32'b01);

    // T2: reload with 5-cycle memory latency
    ctrl_mem_req_valid = 1'b0;
    mem_lat = 5;
    clear_tallies();
    pulse_start();
    chk("t5_reload", {30'd0, busy, done}, 32'b10);
    bad_addr = 0; ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (mem_req_valid && mem_req_addr != BASE) bad_addr++;
      if (mem_req_ready) begin ok = 1'b1; break; end
    end
    chk("t2_first_ready", {31'd0, ok}, 32'd1);
    chk("t2_addr_hold", 32'(bad_addr), 32'd0);
    chk("t2_no_early_we", 32'(wr_count), 32'd0);
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (mem_req_valid) begin ok = 1'b1; break; end
    end
    chk("t2_second_req", {31'd0, ok}, 32'd1);
    chk("t2_second_addr", mem_req_addr, 32'h0001_0004);
    chk("t2_one_write", 32'(wr_count), 32'd1);
    // T5: start mid-load is ignored
    pulse_start();
    wait_done(5000, ok);
    chk("t2_timeout", {31'd0, ok}, 32'd1);
    check_full_load("t2");

    // T6: spurious ready in every gap cycle
    mem_lat = 0; spur_gap = 1'b1;
    clear_tallies();
    pulse_start();
    wait_done(2000, ok);
    chk("t6_timeout", {31'd0, ok}, 32'd1);
    check_full_load("t6");
    spur_gap = 1'b0;

    // T4: asynchronous reset at word 20, then a fresh load
    clear_tallies();
    pulse_start();
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (wr_count == 20) begin ok = 1'b1; break; end
    end
    chk("t4_reach20", {31'd0, ok}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("t4_async_flags", {28'd0, busy, done, mem_req_valid, ctrl_mem_req_ready}, 32'd0);
    chk("t4_async_addr", mem_req_addr, 32'd0);
    chk("t4_async_we", {29'd0, dict1_write_enable, dict2_write_enable, dict3_write_enable}, 32'd0);
    chk("t4_async_vals", {dict1_write_val, dict2_write_val, dict3_write_val}, 32'd0);
    saved = wr_count;
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();
    chk("t4_no_more_we", 32'(wr_count), 32'(saved));
    chk("t4_idle", {30'd0, busy, done}, 32'd0);
    clear_tallies();
    pulse_start();
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (mem_req_valid) begin ok = 1'b1; break; end
      step();
    end
    chk("t4_req_seen", {31'd0, ok}, 32'd1);
    chk("t4_restart_addr", mem_req_addr, BASE);
    wait_done(2000, ok);
    chk("t4_timeout", {31'd0, ok}, 32'd1);
    check_full_load("t4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
